// File: rtl/imm_decode_pipe_pkg.sv
// ---------------------------------------------------------------------------
// imm_decode_pipe_pkg
// Shared definitions for the immediate decode pipeline: the instruction
// format enumeration (including ILLEGAL), RISC-V major opcode constants and
// the SYSTEM funct3 codes of the immediate CSR instructions.
// ---------------------------------------------------------------------------
package imm_decode_pipe_pkg;

    typedef enum logic [2:0] {
        TYPE_R       = 3'd0,
        TYPE_I       = 3'd1,
        TYPE_S       = 3'd2,
        TYPE_B       = 3'd3,
        TYPE_U       = 3'd4,
        TYPE_J       = 3'd5,
        TYPE_ILLEGAL = 3'd6
    } instruction_type_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // CSRRWI / CSRRSI / CSRRCI carry a 5-bit zero-extended uimm in rs1.
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

endpackage

// File: rtl/imm_format_decode.sv
// ---------------------------------------------------------------------------
// imm_format_decode
// Purely combinational: opcode -> instruction format, plus formation of the
// sign-extended XLEN-wide immediate.
//
// Optional build macro: ZICSR_IMM_EN -- when defined, CSRRWI/CSRRSI/CSRRCI
// return the zero-extended uimm (instr[19:15]) instead of instr[31:20].
//
// Ports:
//   instr    in   32    raw instruction word
//   itype    out  3     decoded format (TYPE_ILLEGAL for unknown opcodes)
//   imm      out  XLEN  sign-extended immediate, 0 for R and ILLEGAL
//   pcrel    out  1     target = pc + imm is meaningful (B, J, AUIPC)
//   illegal  out  1     unknown opcode or non-32-bit encoding
// ---------------------------------------------------------------------------
module imm_format_decode
    import imm_decode_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic [31:0]       instr,
    output instruction_type_t itype,
    output logic [XLEN-1:0]   imm,
    output logic              pcrel,
    output logic              illegal
);

    logic [6:0]  opcode;
    logic [31:0] imm32;

    assign opcode = instr[6:0];

    // NOTE: every output of this block gets a default first, so no path
    // through the case statements leaves a value unassigned (no latches).
    always_comb begin
        itype = TYPE_ILLEGAL;
        pcrel = 1'b0;
        case (opcode)
            OPC_LUI:   itype = TYPE_U;
            OPC_AUIPC: begin itype = TYPE_U; pcrel = 1'b1; end
            OPC_JAL:   begin itype = TYPE_J; pcrel = 1'b1; end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:
                       itype = TYPE_I;
            OPC_STORE:  itype = TYPE_S;
            OPC_BRANCH: begin itype = TYPE_B; pcrel = 1'b1; end
            OPC_OP:     itype = TYPE_R;
            OPC_OP_IMM_32: if (RV64_OPS) itype = TYPE_I;
            OPC_OP_32:     if (RV64_OPS) itype = TYPE_R;
            default: ;
        endcase

        // All formats keep their sign in instr[31], so a 32-bit signed
        // intermediate sign-extends correctly to any XLEN.
        case (itype)
            TYPE_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            TYPE_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            TYPE_U: imm32 = {instr[31:12], 12'b0};
            TYPE_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'(signed'(imm32));

`ifdef ZICSR_IMM_EN
        if (opcode == OPC_SYSTEM &&
            (instr[14:12] == F3_CSRRWI || instr[14:12] == F3_CSRRSI ||
             instr[14:12] == F3_CSRRCI)) begin
            imm = XLEN'(instr[19:15]);
        end
`endif
    end

    assign illegal = (itype == TYPE_ILLEGAL) || (instr[1:0] != 2'b11);

endmodule

// File: rtl/imm_decode_pipe.sv
// ---------------------------------------------------------------------------
// imm_decode_pipe
// Two-stage valid/ready pipeline between fetch and register read. Stage 1
// decodes format and immediate from the opcode; stage 2 adds the
// PC-relative target (pc + imm, modulo 2^XLEN) for B, J and AUIPC.
//
// Optional build macro: ZICSR_IMM_EN (see imm_format_decode).
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous kill of both stages; blocks input that cycle
//   in_valid/ready  input handshake; in_ready is combinational on out_ready
//   in_instr        32-bit instruction word
//   in_pc           XLEN-bit instruction PC
//   out_valid/ready output handshake
//   out_type        instruction_type_t
//   out_imm         sign-extended immediate
//   out_target      pc + imm for B/J/AUIPC, else 0
//   out_pc          passthrough PC
//   out_illegal     unrecognised opcode or instr[1:0] != 2'b11
// ---------------------------------------------------------------------------
module imm_decode_pipe
    import imm_decode_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = (XLEN == 64)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output instruction_type_t out_type,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_target,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        instruction_type_t itype;
        logic [XLEN-1:0]   imm;
        logic              illegal;
        logic              pcrel;
    } imm_stage_t;

    localparam imm_stage_t STAGE_RESET = '{
        pc: '0, itype: TYPE_ILLEGAL, imm: '0, illegal: 1'b0, pcrel: 1'b0
    };

    imm_stage_t        dec;
    imm_stage_t        s1_q, s2_q;
    logic              s1_valid, s2_valid;
    logic [XLEN-1:0]   s2_target;
    logic              s1_adv, s2_adv;

    imm_format_decode #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_decode (
        .instr   (in_instr),
        .itype   (dec.itype),
        .imm     (dec.imm),
        .pcrel   (dec.pcrel),
        .illegal (dec.illegal)
    );
    assign dec.pc = in_pc;

    // A stage may take new data when it is empty or its contents leave.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !flush;

    // NOTE: datapath registers are reset too, because the output values
    // seen during reset (type ILLEGAL, zeros) are part of the interface.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_q      <= STAGE_RESET;
            s2_q      <= STAGE_RESET;
            s2_target <= '0;
        end else if (flush) begin
            // Data is left untouched; only the valids drop.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q      <= s1_q;
                    s2_target <= s1_q.pcrel ? (s1_q.pc + s1_q.imm) : '0;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= dec;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_type    = s2_q.itype;
    assign out_imm     = s2_q.imm;
    assign out_target  = s2_target;
    assign out_pc      = s2_q.pc;
    assign out_illegal = s2_q.illegal;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_pipe
// Directed bench for imm_decode_pipe. dut32 (XLEN=32) runs through a
// negedge scoreboard that checks content, order and stall stability;
// dut64 (XLEN=64) is exercised with single directed transactions.
// ---------------------------------------------------------------------------
module tb_imm_decode_pipe;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_IL = 3'd6;

`ifdef ZICSR_IMM_EN
    localparam logic [31:0] CSR_IMM = 32'h0000_0001;
`else
    localparam logic [31:0] CSR_IMM = 32'h0000_0340;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 32-bit DUT
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_target, out_pc;
    logic [2:0]  out_type;

    // 64-bit DUT
    logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic        out_illegal_b;
    logic [31:0] in_instr_b;
    logic [63:0] in_pc_b, out_imm_b, out_target_b, out_pc_b;
    logic [2:0]  out_type_b;

    imm_decode_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_imm(out_imm), .out_target(out_target),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    imm_decode_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_instr(in_instr_b), .in_pc(in_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_type(out_type_b), .out_imm(out_imm_b), .out_target(out_target_b),
        .out_pc(out_pc_b), .out_illegal(out_illegal_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [31:0] target;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t mon_e;
    int   n_out = 0;
    logic saw_bp = 1'b0;
    logic prev_stall = 1'b0;
    logic [4:0]  prev_ctrl;
    logic [31:0] prev_imm, prev_tgt, prev_pc;

    // Scoreboard for dut32, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_ctrl", {out_valid, out_type, out_illegal}, prev_ctrl);
                check("hold_imm", out_imm, prev_imm);
                check("hold_target", out_target, prev_tgt);
                check("hold_pc", out_pc, prev_pc);
            end
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_type", out_type, mon_e.typ);
                    check("out_imm", out_imm, mon_e.imm);
                    check("out_target", out_target, mon_e.target);
                    check("out_pc", out_pc, mon_e.pc);
                    check("out_illegal", out_illegal, mon_e.ill);
                    n_out++;
                end
            end
            if (flush) exp_q.delete();
            if (in_valid && !in_ready) saw_bp = 1'b1;
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            prev_stall = out_valid && !out_ready && !flush;
            prev_ctrl  = {out_valid, out_type, out_illegal};
            prev_imm   = out_imm;
            prev_tgt   = out_target;
            prev_pc    = out_pc;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Present one entry on dut32 and hold it until accepted.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [2:0] typ, input logic [31:0] imm,
                        input logic [31:0] tgt, input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        cur_exp  = '{typ, imm, tgt, pc, ill};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Single transaction on dut64 with out_ready held high.
    task automatic run_b(input string tag, input logic [31:0] instr,
                         input logic [63:0] pc, input logic [2:0] typ,
                         input logic [63:0] imm, input logic [63:0] tgt,
                         input logic ill);
        in_valid_b = 1'b1;
        in_instr_b = instr;
        in_pc_b    = pc;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid_b) break;
        end
        check({tag, "_valid"}, out_valid_b, 1);
        check({tag, "_type"}, out_type_b, typ);
        check({tag, "_imm"}, out_imm_b, imm);
        check({tag, "_target"}, out_target_b, tgt);
        check({tag, "_illegal"}, out_illegal_b, ill);
        @(posedge clk); #1;
    endtask

    int n_base;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; in_instr_b = '0; in_pc_b = '0;
        out_ready_b = 1'b1;

        // Reset values
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_type", out_type, T_IL);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_target", out_target, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_b_type", out_type_b, T_IL);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Latency: accepted entry visible two edges later
        send(32'hFFF00093, 32'h0, T_I, 32'hFFFF_FFFF, 32'h0, 1'b0);
        @(negedge clk);
        check("lat_not_yet", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_two_cycles", out_valid, 1);
        drain();

        // Back-to-back formats, full throughput
        send(32'hFE112E23, 32'h004, T_S, 32'hFFFF_FFFC, 32'h0, 1'b0);
        send(32'hFF9FF06F, 32'h100, T_J, 32'hFFFF_FFF8, 32'h0000_00F8, 1'b0);
        send(32'hFE000EE3, 32'h200, T_B, 32'hFFFF_FFFC, 32'h0000_01FC, 1'b0);
        send(32'h00001017, 32'h300, T_U, 32'h0000_1000, 32'h0000_1300, 1'b0);
        send(32'h12345037, 32'h304, T_U, 32'h1234_5000, 32'h0, 1'b0);
        send(32'h002081B3, 32'h308, T_R, 32'h0, 32'h0, 1'b0);
        send(32'h00000000, 32'h30C, T_IL, 32'h0, 32'h0, 1'b1);
        send(32'h0000001B, 32'h310, T_IL, 32'h0, 32'h0, 1'b1);
        send(32'h0080006F, 32'hFFFF_FFFC, T_J, 32'h8, 32'h0000_0004, 1'b0);
        send(32'h3400D073, 32'h400, T_I, CSR_IMM, 32'h0, 1'b0);
        drain();

        // XLEN=64
        run_b("b_lui", 32'h800000B7, 64'h0, T_U, 64'hFFFF_FFFF_8000_0000, 64'h0, 1'b0);
        run_b("b_zero", 32'h00000000, 64'h8, T_IL, 64'h0, 64'h0, 1'b1);
        run_b("b_addiw", 32'h0010809B, 64'h10, T_I, 64'h1, 64'h0, 1'b0);
        run_b("b_auipc", 32'hFFFFF017, 64'h2000, T_U, 64'hFFFF_FFFF_FFFF_F000,
              64'h1000, 1'b0);

        // Back-pressure: out_ready low for cycles 3..5
        n_base = n_out;
        saw_bp = 1'b0;
        fork
            begin
                send(32'h00100093, 32'h500, T_I, 32'h1, 32'h0, 1'b0);
                send(32'h00200093, 32'h504, T_I, 32'h2, 32'h0, 1'b0);
                send(32'h00300093, 32'h508, T_I, 32'h3, 32'h0, 1'b0);
                send(32'h00400093, 32'h50C, T_I, 32'h4, 32'h0, 1'b0);
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    out_ready = !(c >= 3 && c <= 5);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", saw_bp, 1);
        check("bp_out_count", n_out - n_base, 4);

        // Flush with both stages full
        out_ready = 1'b0;
        send(32'h00A00093, 32'h600, T_I, 32'hA, 32'h0, 1'b0);
        send(32'h00B00093, 32'h604, T_I, 32'hB, 32'h0, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00C00093;
        in_pc    = 32'h608;
        cur_exp  = '{T_I, 32'hC, 32'h0, 32'h608, 1'b0};
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n_base = n_out;
        send(32'h00D00093, 32'h60C, T_I, 32'hD, 32'h0, 1'b0);
        drain();
        check("flush_out_count", n_out - n_base, 1);

        // Asynchronous reset mid-operation
        send(32'h00E00093, 32'h700, T_I, 32'hE, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_base = n_out;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_output", n_out - n_base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
